// File: rtl/lcd_timing_pkg.sv
// Shared types and constants for the LCD scan sequencer.
// Contents: scan state enum, counter width, per-axis total helper.
// Used by lcd_axis_cnt and lcd_timing_ctrl.
package lcd_timing_pkg;

    // Counter width for both axes; totals must fit in it.
    localparam int CNT_W   = 11;
    localparam int CNT_MAX = 2047;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    // Length of one axis period: active + front porch + sync + back porch.
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/lcd_axis_cnt.sv
// One-dimension scan counter (used once for H, once for V).
// Ports: clk/rst, clr (force to 0), inc (advance), cnt, wrap (at last count),
//        active (cnt < ACTIVE), sync (cnt inside the sync pulse window).
module lcd_axis_cnt
    import lcd_timing_pkg::*;
#(
    parameter int ACTIVE = 480,
    parameter int FP     = 8,
    parameter int SYNC   = 4,
    parameter int BP     = 43
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             active,
    output logic             sync
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    if (TOTAL > CNT_MAX || TOTAL < 1) begin : g_total_err
        $error("lcd_axis_cnt: axis total %0d outside 1..%0d", TOTAL, CNT_MAX);
    end

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign wrap   = (cnt_q == LAST);
    assign active = (cnt_q < ACT_END);
    assign sync   = (cnt_q >= SYNC_LO) && (cnt_q < SYNC_HI);

endmodule

// File: rtl/lcd_timing_ctrl.sv
// RGB LCD scan sequencer: H/V counters, DEN/X/Y/FRAME_START, panel DE/HS/VS, BUSY.
// Ports: CLK, RST (sync, active high), EN (level scan enable) in; DEN, X, Y,
//        FRAME_START, LCD_DE, LCD_HS (low active), LCD_VS (low active), BUSY out.
// Optional macro LCD_TIMING_ALIGN_EN adds one register stage on LCD_DE/HS/VS.
module lcd_timing_ctrl
    import lcd_timing_pkg::*;
#(
    parameter int LCD_WIDTH  = 480,
    parameter int LCD_HEIGHT = 272,
    parameter int H_FP       = 8,
    parameter int H_SYNC     = 4,
    parameter int H_BP       = 43,
    parameter int V_FP       = 8,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 12
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    output logic             DEN,
    output logic [CNT_W-1:0] X,
    output logic [CNT_W-1:0] Y,
    output logic             FRAME_START,
    output logic             LCD_DE,
    output logic             LCD_HS,
    output logic             LCD_VS,
    output logic             BUSY
);

    state_e state_q, state_d;

    logic             scan_on;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, h_active, h_sync;
    logic             v_wrap, v_active, v_sync;
    logic             frame_last;

    // Counters only move while scanning; IDLE pins them at the origin.
    assign scan_on    = (state_q != ST_IDLE);
    assign frame_last = h_wrap && v_wrap;

    lcd_axis_cnt #(
        .ACTIVE (LCD_WIDTH),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_cnt (
        .clk    (CLK),
        .rst    (RST),
        .clr    (!scan_on),
        .inc    (scan_on),
        .cnt    (h_cnt),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync)
    );

    lcd_axis_cnt #(
        .ACTIVE (LCD_HEIGHT),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_cnt (
        .clk    (CLK),
        .rst    (RST),
        .clr    (!scan_on),
        .inc    (scan_on && h_wrap),
        .cnt    (v_cnt),
        .wrap   (v_wrap),
        .active (v_active),
        .sync   (v_sync)
    );

    // Next state. In STOP an EN rise beats the frame-end exit, so a re-enable
    // landing on the last pixel rolls straight into the next frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (EN) state_d = ST_RUN;
            ST_RUN:  if (!EN) state_d = ST_STOP;
            ST_STOP: begin
                if (EN) begin
                    state_d = ST_RUN;
                end else if (frame_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the current counters; registered below so every
    // output lags the counters by one clock and stays mutually aligned.
    logic             den_d, fs_d, hs_d, vs_d, busy_d;
    logic [CNT_W-1:0] x_d, y_d;
    logic             den_q, fs_q, hs_q, vs_q, busy_q;
    logic [CNT_W-1:0] x_q, y_q;

    always_comb begin
        den_d  = scan_on && h_active && v_active;
        x_d    = den_d ? h_cnt : '0;
        y_d    = den_d ? v_cnt : '0;
        fs_d   = scan_on && (h_cnt == '0) && (v_cnt == '0);
        hs_d   = !(scan_on && h_sync);
        vs_d   = !(scan_on && v_sync);
        busy_d = scan_on;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            den_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            fs_q    <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            den_q   <= den_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fs_q    <= fs_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            busy_q  <= busy_d;
        end
    end

    assign DEN         = den_q;
    assign X           = x_q;
    assign Y           = y_q;
    assign FRAME_START = fs_q;
    assign BUSY        = busy_q;

`ifdef LCD_TIMING_ALIGN_EN
    // Panel pins delayed one clock to line up with a registered colour path.
    logic de_dly_q, hs_dly_q, vs_dly_q;
    logic de_dly_d, hs_dly_d, vs_dly_d;

    always_comb begin
        de_dly_d = den_q;
        hs_dly_d = hs_q;
        vs_dly_d = vs_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            de_dly_q <= 1'b0;
            hs_dly_q <= 1'b1;
            vs_dly_q <= 1'b1;
        end else begin
            de_dly_q <= de_dly_d;
            hs_dly_q <= hs_dly_d;
            vs_dly_q <= vs_dly_d;
        end
    end

    assign LCD_DE = de_dly_q;
    assign LCD_HS = hs_dly_q;
    assign LCD_VS = vs_dly_q;
`else
    assign LCD_DE = den_q;
    assign LCD_HS = hs_q;
    assign LCD_VS = vs_q;
`endif

endmodule

// File: doc/lcd_timing_ctrl.md
# lcd_timing_ctrl

Scan sequencer for the RGB LCD panel. It generates the horizontal and vertical counters, sync strobes and data-enable. It drives the pattern generator's DEN/X/Y inputs and the panel's DE/HSYNC/VSYNC pins. Scanning is started and stopped with a level enable, and a stop only takes effect at a frame boundary.

## Interface
- LCD_WIDTH, 480, active pixels per line
- LCD_HEIGHT, 272, active lines per frame
- H_FP, 8, horizontal front porch (clocks)
- H_SYNC, 4, HSYNC pulse width (clocks)
- H_BP, 43, horizontal back porch (clocks)
- V_FP, 8, vertical front porch (lines)
- V_SYNC, 4, VSYNC pulse width (lines)
- V_BP, 12, vertical back porch (lines)
- CLK  in  1  pixel clock. Single clock domain.
- RST  in  1  synchronous, active-high reset
- EN  in  1  scan enable (level)
- DEN  out  1  active-region flag to the pattern generator
- X  out  11  pixel column; 0 outside the active region
- Y  out  11  pixel row; 0 outside the active region
- FRAME_START  out  1  one-cycle pulse at pixel (0,0)
- LCD_DE  out  1  panel data enable
- LCD_HS  out  1  panel HSYNC, active low
- LCD_VS  out  1  panel VSYNC, active low
- BUSY  out  1  high in RUN or STOP

## Operation
- Totals:
  - H_TOTAL = LCD_WIDTH+H_FP+H_SYNC+H_BP (default 535).
  - V_TOTAL = LCD_HEIGHT+V_FP+V_SYNC+V_BP (default 296).
  - Both totals must be ≤2047; this is checked at elaboration.
- Counter hcnt runs 0..H_TOTAL-1. It wraps to 0, and vcnt increments when hcnt = H_TOTAL-1.
- Counter vcnt runs 0..V_TOTAL-1 and wraps to 0.
- Line order: active [0, W-1], then front porch, then sync, then back porch. Frame order is the same, counted in lines.
- HS is low for hcnt in [W+H_FP, W+H_FP+H_SYNC-1] on every line, including blanking lines.
- VS is low for vcnt in [H+V_FP, H+V_FP+V_SYNC-1] for whole lines.
- DEN = (hcnt<W) && (vcnt<H). X = hcnt and Y = vcnt when DEN is high, otherwise 0.
- States:
  - IDLE: counters held at 0, outputs inactive. EN=1 → RUN.
  - RUN: counters advance every cycle. EN=0 → STOP.
  - STOP: counters keep advancing.
    - EN=1 → RUN, with the frame uninterrupted.
    - At hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1 → IDLE, counters go to 0.
- If the last pixel of the frame and an EN rise occur in the same cycle while in STOP, RUN wins and the next frame starts immediately.
- FRAME_START pulses in every RUN or STOP cycle where hcnt=0 and vcnt=0, including the first cycle after IDLE→RUN.
- Inactive output levels: DEN=0, X=Y=0, FRAME_START=0, LCD_DE=0, LCD_HS=1, LCD_VS=1.

## Timing
- Reset values: state IDLE, hcnt=vcnt=0, BUSY=0, and every output at its inactive level.
- RST mid-frame aborts the scan with no frame completion, and the next cycle shows reset values.
- All outputs are registered.
- EN sampled 1 in IDLE at cycle N:
  - Cycle N+1: state RUN, hcnt=0, vcnt=0.
  - Cycle N+2: outputs show pixel (0,0) with DEN=1 and FRAME_START=1.
- DEN, X, Y and FRAME_START are mutually aligned.
- LCD_DE, LCD_HS and LCD_VS timing relative to DEN is set per Configuration.
- BUSY is registered alongside the outputs. It is 1 exactly while the outputs reflect RUN or STOP counts.

## Configuration
- LCD_TIMING_ALIGN_EN:
  - Defined: LCD_DE, LCD_HS and LCD_VS pass through one extra register stage, so they lag DEN by one clock. This matches the pattern generator's registered colour output.
  - Undefined: LCD_DE = DEN timing exactly, with HS/VS coincident. Use this when the pixel source is combinational.
  - The extra stage also resets to inactive levels.

## Structure
- Package lcd_timing_pkg:
  - state enum (IDLE, RUN, STOP)
  - counter width constant (11)
  - a function computing the total from active/fp/sync/bp
- Sub-module lcd_axis_cnt: one-dimension counter with increment-enable, wrap flag, active flag and sync flag.
  - Instantiated twice. The H instance is enabled every cycle; the V instance is enabled by the H wrap flag.
  - Parameters: ACTIVE, FP, SYNC, BP.
- The top level holds the FSM, output registers and optional align stage.

## Test plan
- Reset then EN=1 at cycle 5:
  - FRAME_START=1 at cycle 7 with X=0, Y=0, DEN=1.
  - DEN high for exactly 480 consecutive clocks per active line.
  - DEN low for 55 clocks between active lines.
- Full frame:
  - 272×480 = 130560 DEN-high cycles per frame.
  - LCD_HS low 4 clocks starting at hcnt=488 on all 296 lines.
  - LCD_VS low during lines 280–283.
  - Frame period 535×296 = 158360 clocks.
- EN dropped at line 100:
  - Scan continues to vcnt=295, hcnt=534.
  - Then BUSY=0, and outputs are inactive with HS=VS=1.
  - No partial frame.
- EN dropped at line 100 and raised at line 200: no discontinuity; the next FRAME_START comes exactly 158360 clocks after the previous one.
- RST asserted at line 50, pixel 123: the next cycle has all outputs inactive and BUSY=0. Restart via EN gives FRAME_START 2 cycles after EN.
- Build with LCD_TIMING_ALIGN_EN: LCD_DE equals DEN delayed by exactly 1 clock across a full frame.
- Build without LCD_TIMING_ALIGN_EN: LCD_DE equals DEN every cycle.
